return_addr_stack: RTL

- Return-address stack (RAS) for the fetch/EX path. It is the consumer of the link values that JAL/JALR calls produce.
- Pushes the link (pc+4) on a call and pops it on a return (JALR through ra/t0), supplying the predicted return target.
- Circular storage: overflow overwrites the oldest entry, and underflow is flagged. A registered pop response feeds the PC-select mux one cycle later.

---
 rtl/return_addr_stack.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/return_addr_stack.sv
// Return-address stack: circular LIFO of call link addresses.
// Overflow overwrites the oldest entry; underflow is reported as a pulse.
// The pop response (ret_valid/ret_addr) is registered and appears one cycle after pop.
module return_addr_stack #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            pop,
    output logic [XLEN-1:0] top_addr,
    output logic            empty,
    output logic            full,
    output logic [CW-1:0]   count,
    output logic            ret_valid,
    output logic [XLEN-1:0] ret_addr,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    // DEPTH must be a power of two so the pointer wraps for free.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("return_addr_stack: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]   r_tp;
    logic [CW-1:0]   r_count;
    logic            r_ret_valid;
    logic [XLEN-1:0] r_ret_addr;
    logic            r_overflow;
    logic            r_underflow;

    logic [PW-1:0]   w_tp_m1;
    logic [XLEN-1:0] w_top;
    logic            w_empty;
    logic            w_full;

    logic            w_we;
    logic [PW-1:0]   w_waddr;
    logic [PW-1:0]   w_tp_d;
    logic [CW-1:0]   w_count_d;
    logic            w_ret_valid_d;
    logic [XLEN-1:0] w_ret_addr_d;
    logic            w_overflow_d;
    logic            w_underflow_d;

    assign w_tp_m1 = r_tp - PW'(1);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_top   = r_mem[w_tp_m1];

    assign top_addr  = w_empty ? '0 : w_top;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign ret_valid = r_ret_valid;
    assign ret_addr  = r_ret_addr;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Next-state decode for push/pop; clears are applied in the register block.
    always_comb begin
        w_we          = 1'b0;
        w_waddr       = r_tp;
        w_tp_d        = r_tp;
        w_count_d     = r_count;
        w_ret_valid_d = 1'b0;
        w_ret_addr_d  = '0;
        w_overflow_d  = 1'b0;
        w_underflow_d = 1'b0;

        unique case ({push, pop})
            2'b10: begin
                w_we    = 1'b1;
                w_waddr = r_tp;
                w_tp_d  = r_tp + PW'(1);
                if (w_full) begin
                    // Oldest entry is overwritten; count saturates.
                    w_overflow_d = 1'b1;
                end else begin
                    w_count_d = r_count + CW'(1);
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_underflow_d = 1'b1;
                end else begin
                    w_ret_valid_d = 1'b1;
                    w_ret_addr_d  = w_top;
                    w_tp_d        = w_tp_m1;
                    w_count_d     = r_count - CW'(1);
                end
            end
            2'b11: begin
                if (w_empty) begin
                    // Nothing to return: behave as a plain push.
                    w_underflow_d = 1'b1;
                    w_we          = 1'b1;
                    w_waddr       = r_tp;
                    w_tp_d        = r_tp + PW'(1);
                    w_count_d     = CW'(1);
                end else begin
                    // Co-routine swap: return old top, replace it in place.
                    w_ret_valid_d = 1'b1;
                    w_ret_addr_d  = w_top;
                    w_we          = 1'b1;
                    w_waddr       = w_tp_m1;
                end
            end
            default: ;
        endcase
    end

    // Storage array; contents are don't-care after a clear, so no reset.
    always_ff @(posedge clk) begin
        if (w_we && !rst && !flush) begin
            r_mem[w_waddr] <= push_addr;
        end
    end

    // Pointer, count and registered response/pulse state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_ret_valid <= 1'b0;
            r_ret_addr  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_tp        <= w_tp_d;
            r_count     <= w_count_d;
            r_ret_valid <= w_ret_valid_d;
            r_ret_addr  <= w_ret_addr_d;
            r_overflow  <= w_overflow_d;
            r_underflow <= w_underflow_d;
        end
    end

endmodule
